// File: rtl/quad_step_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : quad_step_tx                                                |
// | Brief   : Quadrature step transmitter. Accepts left/right step        |
// |           requests over valid/ready and drives a Gray-coded qa/qb     |
// |           pair, holding each phase for DWELL cycles, with a running   |
// |           modulo-2^POS_W position count.                              |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module quad_step_tx #(
   parameter logic [15:0] DWELL      = 16'd65535,
   parameter int          POS_W      = 8,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_valid,
   input  logic             step_dir,
   output logic             step_ready,
   output logic             qa,
   output logic             qb,
   output logic [POS_W-1:0] position,
   output logic             busy
);

   // Dwell counter reload: the phase is held for DWELL cycles, counting
   // DWELL-1 down to 0 inclusive.
   localparam logic [15:0] c_DWELL_LOAD = DWELL - 16'd1;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DWELL = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic [1:0]         r_ph;
   logic [1:0]         w_ph_nxt;
   logic [15:0]        r_cnt;
   logic [POS_W-1:0]   r_pos;
   logic               r_qa;
   logic               r_qb;

   // Gray stepping: right walks 00->01->11->10, left walks it backwards.
   // Each move flips exactly one bit of the phase.
   assign w_ph_nxt = step_dir ? {r_ph[0], ~r_ph[1]}
                              : {~r_ph[0], r_ph[1]};

   assign qa       = r_qa;
   assign qb       = r_qb;
   assign position = r_pos;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and handshake decode; ready depends on state only
   always_comb begin
      w_state_nxt = r_state;
      step_ready  = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            step_ready = 1'b1;
            if (step_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_DWELL;
            end
         end
         S_DWELL: begin
            busy = 1'b1;
            if (r_cnt == 16'd0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Phase, pins, position and dwell counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ph  <= 2'b00;
         r_qa  <= ACTIVE_LOW;
         r_qb  <= ACTIVE_LOW;
         r_pos <= '0;
         r_cnt <= 16'd0;
      end else if (w_accept) begin
         r_ph  <= w_ph_nxt;
         r_qa  <= w_ph_nxt[1] ^ ACTIVE_LOW;
         r_qb  <= w_ph_nxt[0] ^ ACTIVE_LOW;
         r_pos <= step_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
         r_cnt <= c_DWELL_LOAD;
      end else if ((r_state == S_DWELL) && (r_cnt != 16'd0)) begin
         r_cnt <= r_cnt - 16'd1;
      end
   end

endmodule
`default_nettype wire
